uart_tx: RTL and testbench

- Serial transmitter for the UART datapath. Sits directly downstream of baud_gen and consumes its one-cycle tick_baud strobe.
- Accepts one parallel byte per valid/ready handshake and shifts it out LSB-first as an asynchronous frame on a single line: start, data, optional parity, stop.
- Every bit boundary is aligned to a tick_baud pulse, so every bit after the start edge lasts exactly one baud period.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx.sv | 144 ++++++++++++++
 tb/tb_uart_tx.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line levels and the
// parity helper that the receiver will reuse.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE     = 1'b1;
   localparam logic LINE_START    = 1'b0;
   localparam int   MAX_DATA_BITS = 9;

   // Narrower words must be zero-extended by the caller so unused bits do not
   // disturb the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                      odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, shifted out LSB-first
// with start, optional parity and 1..2 stop bits, each bit aligned to tick_baud.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_baud,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx_serial
);

   localparam int CNT_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
      $fatal(1, "uart_tx: DATA_BITS must be 5..9");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
   end

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 parity_q, parity_d;
   logic                 serial_q, serial_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 accept;

   assign accept = tx_valid && ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         serial_q   <= LINE_IDLE;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         serial_q   <= serial_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Only the accept ignores tick_baud; a tick in the accept cycle is dropped
   // because the FSM is still in IDLE on that edge.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = WAIT;
         WAIT:    if (tick_baud) state_d = START;
         START:   if (tick_baud) state_d = DATA;
         DATA:    if (tick_baud && bit_cnt_q == LAST_BIT)
                     state_d = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (tick_baud) state_d = STOP;
         STOP:    if (tick_baud && stop_cnt_q == LAST_STOP) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs and datapath: each value is the level for the bit that
   // starts on this edge.
   always_comb begin
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      serial_d   = serial_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            serial_d = LINE_IDLE;
            if (accept) begin
               shift_d  = tx_data;
               parity_d = calc_parity(MAX_DATA_BITS'(tx_data), PARITY_ODD != 0);
               ready_d  = 1'b0;
               busy_d   = 1'b1;
            end
         end
         WAIT: if (tick_baud) serial_d = LINE_START;
         START: if (tick_baud) begin
            serial_d  = shift_q[0];
            bit_cnt_d = '0;
         end
         DATA: if (tick_baud) begin
            if (bit_cnt_q == LAST_BIT) begin
               serial_d   = (PARITY_EN != 0) ? parity_q : LINE_IDLE;
               stop_cnt_d = 1'b0;
            end else begin
               shift_d   = shift_q >> 1;
               serial_d  = shift_q[1];
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         PARITY: if (tick_baud) begin
            serial_d   = LINE_IDLE;
            stop_cnt_d = 1'b0;
         end
         STOP: if (tick_baud) begin
            if (stop_cnt_q == LAST_STOP) begin
               ready_d = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: serial_d = LINE_IDLE;
      endcase
   end

   assign tx_serial = serial_q;
   assign tx_ready  = ready_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: five parameterisations, frames captured cycle by
// cycle and decoded against hand-computed bit patterns.
module tb_uart_tx;

   logic       clk, rst, tick, tick5;
   logic [7:0] tx_data;
   logic       vld  [5];
   logic       rdy  [5];
   logic       busy [5];
   logic       done [5];
   logic       ser  [5];

   int   n_chk = 0, n_fail = 0;
   int   cyc = 0;
   logic tick_en = 1'b0;

   logic trc[$];
   int   d_idx, n_done, n_rdy_bad;

   uart_tx dut0 (.clk(clk), .rst(rst), .tick_baud(tick), .tx_data(tx_data), .tx_valid(vld[0]),
                 .tx_ready(rdy[0]), .tx_busy(busy[0]), .tx_done(done[0]), .tx_serial(ser[0]));
   uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk(clk), .rst(rst), .tick_baud(tick),
                 .tx_data(tx_data), .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_busy(busy[1]),
                 .tx_done(done[1]), .tx_serial(ser[1]));
   uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk(clk), .rst(rst), .tick_baud(tick),
                 .tx_data(tx_data), .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_busy(busy[2]),
                 .tx_done(done[2]), .tx_serial(ser[2]));
   uart_tx #(.STOP_BITS(2)) dut3 (.clk(clk), .rst(rst), .tick_baud(tick), .tx_data(tx_data),
                 .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx_busy(busy[3]), .tx_done(done[3]),
                 .tx_serial(ser[3]));
   uart_tx #(.DATA_BITS(5)) dut4 (.clk(clk), .rst(rst), .tick_baud(tick5), .tx_data(tx_data[4:0]),
                 .tx_valid(vld[4]), .tx_ready(rdy[4]), .tx_busy(busy[4]), .tx_done(done[4]),
                 .tx_serial(ser[4]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1 ns later; tick is the value for the next edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      tick = tick_en && (cyc % 4 == 0);
   endtask

   // drop_at >= 0: release tx_valid after that trace index; -1: after the edge
   // following the first tx_done; -2: never touched.
   task automatic capture(input int k, input int budget, input int ndone, input int drop_at);
      int   tail;
      logic drop_next;
      tail = -1;
      drop_next = 1'b0;
      trc.delete();
      d_idx = -1;
      n_done = 0;
      n_rdy_bad = 0;
      for (int i = 0; i < budget; i++) begin
         step();
         trc.push_back(ser[k]);
         if (drop_next || i == drop_at) vld[k] = 1'b0;
         drop_next = 1'b0;
         if (d_idx < 0 && !done[k] && rdy[k]) n_rdy_bad++;
         if (done[k]) begin
            n_done++;
            if (d_idx < 0) d_idx = i;
            if (n_done == 1 && drop_at == -1) drop_next = 1'b1;
            if (n_done == ndone) tail = i + 3;
         end
         if (i == tail) break;
      end
   endtask

   function automatic int find_low(input int from);
      for (int j = (from < 0 ? 0 : from); j < trc.size(); j++)
         if (trc[j] == 1'b0) return j;
      return -1;
   endfunction

   // Bit i of the result is the line level in the middle of bit period i.
   function automatic logic [15:0] frame(input int s, input int n, input int p);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < n; i++) begin
         int j;
         j = s + i * p + p / 2;
         r[i] = (s >= 0 && j < trc.size()) ? trc[j] : 1'bx;
      end
      return r;
   endfunction

   function automatic int glitches(input int s, input int n, input int p);
      int g;
      g = 0;
      if (s < 0 || s + n * p > trc.size()) return 999;
      for (int j = s; j < s + n * p; j++)
         if (trc[j] != trc[s + ((j - s) / p) * p]) g++;
      return g;
   endfunction

   initial begin
      int s, s2, cnt;
      rst = 1'b1;
      tick = 1'b0;
      tick5 = 1'b0;
      tx_data = '0;
      for (int k = 0; k < 5; k++) vld[k] = 1'b0;
      repeat (3) step();
      chk("rst_serial", 32'(ser[0]), 32'd1);
      chk("rst_ready", 32'(rdy[0]), 32'd1);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      rst = 1'b0;
      tick_en = 1'b1;
      repeat (2) step();

      // 0x55, 8N1: start, 1,0,1,0,1,0,1,0, stop
      tx_data = 8'h55; vld[0] = 1'b1; step(); vld[0] = 1'b0;
      capture(0, 80, 1, -2);
      s = find_low(0);
      chk("t1_frame", 32'(frame(s, 10, 4)), 32'h2AA);
      chk("t1_len", d_idx - s, 40);
      chk("t1_hold", glitches(s, 10, 4), 0);
      chk("t1_done_cnt", n_done, 1);
      chk("t1_ready_low", n_rdy_bad, 0);

      // 0x07 with even parity -> parity 1; odd -> parity 0
      tx_data = 8'h07; vld[1] = 1'b1; step(); vld[1] = 1'b0;
      capture(1, 80, 1, -2);
      s = find_low(0);
      chk("t2_even_frame", 32'(frame(s, 11, 4)), 32'h60E);
      chk("t2_even_len", d_idx - s, 44);
      tx_data = 8'h07; vld[2] = 1'b1; step(); vld[2] = 1'b0;
      capture(2, 80, 1, -2);
      s = find_low(0);
      chk("t2_odd_frame", 32'(frame(s, 11, 4)), 32'h40E);
      chk("t2_odd_len", d_idx - s, 44);

      // Two stop bits, back-to-back with tx_valid held through the first frame
      tx_data = 8'hA3; vld[3] = 1'b1; step(); tx_data = 8'h3C;
      capture(3, 150, 2, -1);
      s = find_low(0);
      chk("t3_frame1", 32'(frame(s, 11, 4)), 32'h746);
      chk("t3_len1", d_idx - s, 44);
      s2 = find_low(d_idx);
      // Accept lands one cycle after done; start waits for the next tick.
      chk("t3_restart", s2 - d_idx, 4);
      chk("t3_frame2", 32'(frame(s2, 11, 4)), 32'h678);
      chk("t3_done_cnt", n_done, 2);

      // Accept coinciding with a tick, then busy-time valid with other data
      for (int i = 0; i < 8 && !tick; i++) step();
      tx_data = 8'h96; vld[0] = 1'b1; step();
      tx_data = 8'h3A;
      capture(0, 80, 1, 8);
      s = find_low(0);
      chk("t4_start_delay", s + 1, 4);
      chk("t4_frame", 32'(frame(s, 10, 4)), 32'h32C);
      chk("t4_len", d_idx - s, 40);

      // Reset during data bit 3 of 0xFF
      tx_data = 8'hFF; vld[0] = 1'b1; step(); vld[0] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!ser[0]) break;
      end
      repeat (17) step();
      chk("t5_busy_pre", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_async_serial", 32'(ser[0]), 32'd1);
      chk("t5_async_ready", 32'(rdy[0]), 32'd1);
      chk("t5_async_busy", 32'(busy[0]), 32'd0);
      step();
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (done[0]) cnt++;
      end
      chk("t5_no_done", cnt, 0);
      chk("t5_idle_line", 32'(ser[0]), 32'd1);
      tx_data = 8'h81; vld[0] = 1'b1; step(); vld[0] = 1'b0;
      capture(0, 80, 1, -2);
      s = find_low(0);
      chk("t5_frame", 32'(frame(s, 10, 4)), 32'h302);
      chk("t5_len", d_idx - s, 40);

      // DATA_BITS=5 with tick_baud tied high
      tick5 = 1'b1;
      tx_data = 8'h1F; vld[4] = 1'b1; step(); vld[4] = 1'b0;
      capture(4, 20, 1, -2);
      s = find_low(0);
      chk("t6_start", s, 0);
      chk("t6_frame", 32'(frame(s, 7, 1)), 32'h7E);
      chk("t6_done_edge", d_idx + 1, 8);
      tick5 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
